// File: rtl/key_action_decoder.sv
// Turns the raw 32-bit HID keycode word into held-until-acked Tetris move requests,
// with frame-timed DAS/ARR auto-repeat on left/right and a fixed repeat rate on soft drop.
module key_action_decoder #(
    parameter int DAS_FRAMES  = 10,
    parameter int ARR_FRAMES  = 2,
    parameter int SOFT_FRAMES = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] keycode,
    input  logic        frame_clk,
    input  logic [4:0]  action_ack,
    output logic [4:0]  action_req
);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    localparam logic [5:0] DAS_L  = 6'(DAS_FRAMES);
    localparam logic [5:0] ARR_L  = 6'(ARR_FRAMES);
    localparam logic [5:0] SOFT_L = 6'(SOFT_FRAMES);

    function automatic logic key_present(input logic [31:0] kc,
                                         input logic [7:0]  code_a,
                                         input logic [7:0]  code_b);
        logic hit;
        hit = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (kc[8*b +: 8] == code_a || kc[8*b +: 8] == code_b) hit = 1'b1;
        end
        return hit;
    endfunction

    logic [4:0] held_now, held_q, held_prev;
    logic [4:0] held_eff, prev_eff, press;
    logic       conflict_q, conflict_p;
    logic [1:0] frame_sync;
    logic       frame_prev, tick;

    rpt_state_t state_q [3];
    rpt_state_t state_d [3];
    logic [5:0] cnt_q [3];
    logic [5:0] cnt_d [3];
    logic [2:0] rpt_trig;
    logic [4:0] trigger;

    always_comb begin
        held_now[0] = key_present(keycode, 8'h50, 8'h04);
        held_now[1] = key_present(keycode, 8'h4F, 8'h07);
        held_now[2] = key_present(keycode, 8'h51, 8'h16);
        held_now[3] = key_present(keycode, 8'h1D, 8'h14);
        held_now[4] = key_present(keycode, 8'h52, 8'h1A);
    end

    // Left+right together count as neither; masking the previous sample the same way
    // makes the survivor look like a fresh press once the other is released.
    assign conflict_q = held_q[0] & held_q[1];
    assign conflict_p = held_prev[0] & held_prev[1];
    assign held_eff   = held_q    & ~{3'b000, {2{conflict_q}}};
    assign prev_eff   = held_prev & ~{3'b000, {2{conflict_p}}};
    assign press      = held_eff & ~prev_eff;

    // Channels 0/1 run DAS then ARR; channel 2 (soft drop) skips straight to REPEAT.
    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        rpt_trig = '0;
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!held_eff[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (press[i]) begin
                            rpt_trig[i] = 1'b1;
                            cnt_d[i]    = '0;
                            state_d[i]  = (i == 2) ? REPEAT : DELAY;
                        end
                    end
                    DELAY: begin
                        if (tick) begin
                            if (cnt_q[i] + 6'd1 == DAS_L) begin
                                rpt_trig[i] = 1'b1;
                                cnt_d[i]    = '0;
                                state_d[i]  = REPEAT;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 6'd1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (tick) begin
                            if (cnt_q[i] + 6'd1 == ((i == 2) ? SOFT_L : ARR_L)) begin
                                rpt_trig[i] = 1'b1;
                                cnt_d[i]    = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 6'd1;
                            end
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    assign trigger = {press[4], press[3], rpt_trig};

    // NOTE: all state updates use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            held_q     <= '0;
            held_prev  <= '0;
            frame_sync <= '0;
            frame_prev <= 1'b0;
            tick       <= 1'b0;
            action_req <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            held_q     <= held_now;
            held_prev  <= held_q;
            frame_sync <= {frame_sync[0], frame_clk};
            frame_prev <= frame_sync[1];
            tick       <= frame_sync[1] & ~frame_prev;
            // A new trigger wins over a same-cycle ack; repeats while pending coalesce.
            action_req <= trigger | (action_req & ~action_ack);
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_key_action_decoder.sv
// Directed bench for key_action_decoder: a vector table for key mapping and ack
// handling, plus hand-written sequences for DAS/ARR, conflict, soft drop and reset.
module tb_key_action_decoder;

    logic        Clk;
    logic        Reset;
    logic [31:0] keycode;
    logic        frame_clk;
    logic [4:0]  action_ack;
    logic [4:0]  action_req;

    int tests;
    int fails;

    typedef struct packed {
        logic [31:0] kc;
        logic [4:0]  ack;
        logic [4:0]  exp_req;
    } vec_t;

    vec_t vecs [30];

    key_action_decoder #(
        .DAS_FRAMES (10),
        .ARR_FRAMES (2),
        .SOFT_FRAMES(3)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .frame_clk (frame_clk),
        .action_ack(action_ack),
        .action_req(action_req)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: action_req=%b expected %b at %0t", name, act, exp_v, $time);
        end
    endtask

    // One VS pulse: high 4 cycles, low 4 cycles; any tick-driven trigger lands inside it.
    task automatic pulse_tick();
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic ack_pulse(input string name, input logic [4:0] m);
        action_ack = m;
        @(negedge Clk);
        action_ack = '0;
        check(name, action_req, 5'b00000);
    endtask

    task automatic release_all(input string name);
        keycode = '0;
        repeat (3) @(negedge Clk);
        check(name, action_req, 5'b00000);
    endtask

    task automatic press_key(input string name, input logic [31:0] kc, input logic [4:0] exp_v);
        keycode = kc;
        @(negedge Clk);
        check({name, "_edge1"}, action_req, 5'b00000);
        @(negedge Clk);
        check({name, "_edge2"}, action_req, exp_v);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        Reset      = 1'b1;
        keycode    = '0;
        frame_clk  = 1'b0;
        action_ack = '0;

        vecs[0]  = '{32'h0000_0000, 5'b00000, 5'b00000};
        vecs[1]  = '{32'h0000_0050, 5'b00000, 5'b00000};
        vecs[2]  = '{32'h0000_0050, 5'b00000, 5'b00001};
        vecs[3]  = '{32'h0000_0050, 5'b00000, 5'b00001};
        vecs[4]  = '{32'h0000_0050, 5'b00001, 5'b00000};
        vecs[5]  = '{32'h0000_0050, 5'b00000, 5'b00000};
        vecs[6]  = '{32'h0000_0000, 5'b00000, 5'b00000};
        vecs[7]  = '{32'h0000_0000, 5'b00010, 5'b00000};
        vecs[8]  = '{32'h0000_1D00, 5'b00000, 5'b00000};
        vecs[9]  = '{32'h0000_1D00, 5'b00000, 5'b01000};
        vecs[10] = '{32'h0000_1D00, 5'b01000, 5'b00000};
        vecs[11] = '{32'h1400_0000, 5'b00000, 5'b00000};
        vecs[12] = '{32'h0052_0000, 5'b00000, 5'b00000};
        vecs[13] = '{32'h0052_0000, 5'b00000, 5'b10000};
        vecs[14] = '{32'h0052_0000, 5'b10000, 5'b00000};
        vecs[15] = '{32'h0700_0000, 5'b00000, 5'b00000};
        vecs[16] = '{32'h0700_0000, 5'b00000, 5'b00010};
        vecs[17] = '{32'h0000_0000, 5'b00010, 5'b00000};
        vecs[18] = '{32'h0000_0016, 5'b00000, 5'b00000};
        vecs[19] = '{32'h0000_0016, 5'b00000, 5'b00100};
        vecs[20] = '{32'h0000_0000, 5'b00100, 5'b00000};
        vecs[21] = '{32'h1D52_0000, 5'b00000, 5'b00000};
        vecs[22] = '{32'h1D52_0000, 5'b00000, 5'b11000};
        vecs[23] = '{32'h0000_0000, 5'b11000, 5'b00000};
        vecs[24] = '{32'h0000_0000, 5'b11111, 5'b00000};
        vecs[25] = '{32'h5000_0000, 5'b00000, 5'b00000};
        vecs[26] = '{32'h5000_0000, 5'b00000, 5'b00001};
        vecs[27] = '{32'h0000_0000, 5'b00001, 5'b00000};
        vecs[28] = '{32'h0000_0005, 5'b00000, 5'b00000};
        vecs[29] = '{32'h0000_0005, 5'b00000, 5'b00000};

        repeat (2) @(negedge Clk);
        check("reset_state", action_req, 5'b00000);
        Reset = 1'b0;

        // Key mapping, press latency, ack, coalescing and ignored acks.
        for (int v = 0; v < 30; v++) begin
            keycode    = vecs[v].kc;
            action_ack = vecs[v].ack;
            @(negedge Clk);
            check($sformatf("vec%0d", v), action_req, vecs[v].exp_req);
        end
        action_ack = '0;
        release_all("rel_after_table");

        // Left DAS/ARR: press, then tick 10, 12, 14, 16.
        press_key("das_press", 32'h0000_0004, 5'b00001);
        ack_pulse("das_press_ack", 5'b00001);
        for (int t = 1; t <= 16; t++) begin
            logic [4:0] e;
            pulse_tick();
            e = (t == 10 || t == 12 || t == 14 || t == 16) ? 5'b00001 : 5'b00000;
            check($sformatf("das_tick%0d", t), action_req, e);
            if (e != 5'b00000) ack_pulse($sformatf("das_ack%0d", t), e);
        end
        release_all("rel_after_das");

        // Left/right conflict suppresses both; releasing left leaves a fresh right press.
        press_key("conflict", 32'h0000_4F50, 5'b00000);
        for (int t = 1; t <= 20; t++) begin
            pulse_tick();
            check($sformatf("conflict_tick%0d", t), action_req, 5'b00000);
        end
        press_key("conflict_resolve", 32'h0000_004F, 5'b00010);
        ack_pulse("conflict_ack", 5'b00010);
        release_all("rel_after_conflict");

        // Rotate never repeats.
        press_key("rot_press", 32'h0000_001A, 5'b10000);
        ack_pulse("rot_ack", 5'b10000);
        for (int t = 1; t <= 30; t++) begin
            pulse_tick();
            check($sformatf("rot_tick%0d", t), action_req, 5'b00000);
        end
        release_all("rel_after_rot");

        // Soft drop: press, then every third tick.
        press_key("soft_press", 32'h0000_0051, 5'b00100);
        ack_pulse("soft_press_ack", 5'b00100);
        for (int t = 1; t <= 9; t++) begin
            logic [4:0] e;
            pulse_tick();
            e = (t % 3 == 0) ? 5'b00100 : 5'b00000;
            check($sformatf("soft_tick%0d", t), action_req, e);
            if (e != 5'b00000) ack_pulse($sformatf("soft_ack%0d", t), e);
        end
        release_all("rel_after_soft");

        // Cycle-exact tick latency, coalescing, and trigger-beats-ack.
        press_key("ta_press", 32'h0000_0050, 5'b00001);
        ack_pulse("ta_press_ack", 5'b00001);
        for (int t = 1; t <= 9; t++) begin
            pulse_tick();
            check($sformatf("ta_tick%0d", t), action_req, 5'b00000);
        end
        frame_clk = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(negedge Clk);
            check($sformatf("tick10_edge%0d", e), action_req, 5'b00000);
        end
        @(negedge Clk);
        check("tick10_edge4", action_req, 5'b00001);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        pulse_tick();
        check("tick11_pending", action_req, 5'b00001);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        action_ack = 5'b00001;
        @(negedge Clk);
        action_ack = '0;
        check("trig_and_ack", action_req, 5'b00001);
        frame_clk = 1'b0;
        @(negedge Clk);
        check("trig_and_ack_hold", action_req, 5'b00001);
        ack_pulse("ack_after_coincide", 5'b00001);
        release_all("rel_after_coincide");

        // Asynchronous reset mid-hold, then the still-held key re-triggers.
        press_key("rst_press", 32'h0000_0050, 5'b00001);
        #2 Reset = 1'b1;
        #1 check("reset_async", action_req, 5'b00000);
        repeat (2) @(negedge Clk);
        check("reset_held", action_req, 5'b00000);
        Reset = 1'b0;
        @(negedge Clk);
        check("post_reset_edge1", action_req, 5'b00000);
        @(negedge Clk);
        check("post_reset_edge2", action_req, 5'b00001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_action_decoder.md
# key_action_decoder

Converts the 32-bit USB keyboard keycode word written by the NIOS II PIO into per-action Tetris move requests for `block_logic`. It sits between `nios_system.keycode_export` and the `block_logic` move inputs. It decodes edge-triggered presses, applies frame-timed auto-repeat (DAS/ARR) to left, right and soft-drop, and holds each request until `block_logic` acknowledges it.

## Interface
- `DAS_FRAMES`, default 10: frame ticks a left/right key must be held before its first auto-repeat (legal 1–63).
- `ARR_FRAMES`, default 2: frame ticks between left/right auto-repeats (legal 1–63).
- `SOFT_FRAMES`, default 3: frame ticks between soft-drop repeats while down is held (legal 1–63).
- `Clk` input 1: system clock (CLOCK_50); one clock for all state.
- `Reset` input 1: asynchronous, active-high reset.
- `keycode` input 32: four 8-bit HID usage codes in bytes [7:0], [15:8], [23:16], [31:24]. 0x00 means an empty slot. Synchronous to `Clk`.
- `frame_clk` input 1: VGA_VS. Asynchronous to `Clk`.
- `action_ack` input 5: one-cycle pulse per bit from `block_logic`. Clears the matching request.
- `action_req` output 5: pending requests. Bit order: 0 left, 1 right, 2 down, 3 rotate_left, 4 rotate_right (same as `can_move`).

## Operation
- Key map. A key is present if any of the four bytes equals its code:
  - left: 0x50 or 0x04 (A)
  - right: 0x4F or 0x07 (D)
  - down: 0x51 or 0x16 (S)
  - rotate_left: 0x1D (Z) or 0x14 (Q)
  - rotate_right: 0x52 or 0x1A (W)
- Presence is registered each `Clk` into `held_q[4:0]`. `held_prev[4:0]` holds the previous sample. A press edge is `held_q & ~held_prev`.
- Left/right conflict: if left and right are both present, both are treated as not held. Their FSMs return to IDLE and no trigger is issued. When one is released, the other is seen as a fresh press.
- Frame tick:
  - `frame_clk` passes through a 2-flop synchronizer plus an edge register.
  - `tick` = one-`Clk` pulse on the synchronized rising edge.
- Left and right each have a 6-bit counter and an FSM with states IDLE, DELAY, REPEAT:
  - IDLE → DELAY on press edge. Triggers immediately, cnt=0.
  - DELAY, on tick: if cnt+1==DAS_FRAMES, trigger, cnt=0, → REPEAT; else cnt++.
  - REPEAT, on tick: if cnt+1==ARR_FRAMES, trigger, cnt=0; else cnt++.
  - Any state → IDLE and cnt=0 when the key is not held (this takes priority over tick).
- Down uses the same FSM with DELAY skipped: IDLE → REPEAT on press edge with an immediate trigger. It then triggers every SOFT_FRAMES ticks.
- Rotate_left and rotate_right trigger on the press edge only. They never auto-repeat.
- Request register `action_req[i]` (evaluated per bit):
  - trigger → set
  - ack without trigger → clear
  - trigger and ack in the same cycle → stays 1 (the new event wins)
  - trigger while already pending → coalesced, stays 1, no queueing
  - ack on a bit that is not pending → ignored
- Counters saturate by construction (they reset at match), so they never wrap.

## Timing
- Reset values: `action_req`=0, held_q=0, held_prev=0, synchronizer and edge flops 0, all FSMs IDLE, all counters 0.
- `Reset` clears all state asynchronously. Deassertion is synchronous to `Clk` by use.
- Key-to-request latency, press edge:
  - keycode changes before edge N; held_q updates at N.
  - `action_req` is set at edge N+1 and is visible after edge N+1 (2 edges).
- Frame-tick latency: `tick` is asserted in the cycle after the 3rd `Clk` edge following the VS rise. A repeat trigger sets `action_req` at the edge that samples that tick.
- Ack latency: `action_ack[i]` sampled at edge M → `action_req[i]`=0 after M.
- Reset released while a key is held: held_prev=0, so the key is seen as a fresh press. A request appears 2 edges after the first post-reset edge.
- `frame_clk` pulses narrower than 2 `Clk` periods are not guaranteed to be seen. VGA_VS (≥2 lines) always is.

## Test plan
1. Press and ack:
   - Reset, then keycode=0x00000050 at edge T → `action_req`=5'b00001 after T+1.
   - Stays set until `action_ack`=5'b00001 at edge U → 0 after U.
2. Left DAS/ARR:
   - Hold 0x04 with DAS_FRAMES=10, ARR_FRAMES=2, acking each request.
   - Triggers at press, at tick 10, then at ticks 12, 14, 16 (tick count from the press).
3. Left/right conflict:
   - keycode=0x00004F50 → `action_req`=0 for 20 ticks.
   - keycode=0x0000004F → bit 1 set 2 edges later.
4. Rotate and soft drop:
   - Hold 0x1A for 30 ticks → exactly one bit-4 request.
   - Hold 0x51 with SOFT_FRAMES=3 → triggers at press and at ticks 3, 6, 9.
5. Same-cycle trigger and ack: tick-driven repeat trigger coinciding with an ack on bit 0 → `action_req[0]` remains 1.
6. Reset mid-hold:
   - Hold 0x50, assert `Reset` asynchronously mid-cycle → `action_req`=0 immediately.
   - After release, with the key still held → bit 0 set 2 edges later.
